// File: rtl/intpol2_sq_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : intpol2_sq_gen_if                                               |
// | Brief  : coefficient-in / sample-out valid-ready bundle for the          |
// |          intpol2 quadratic-term generator                                |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
interface intpol2_sq_gen_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_c;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  // master: the generator itself; slave: its upstream/downstream neighbours
  modport master (
    input  s_valid, s_c, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
  modport slave (
    output s_valid, s_c, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );
endinterface
`default_nettype wire

// File: rtl/intpol2_sq_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : intpol2_sq_gen                                                  |
// | Brief  : per coefficient c emits c*k^2, k=1..2**LOG2_L, by second-order  |
// |          difference recursion; optional saturation: INTPOL2_SQ_SAT_EN    |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module intpol2_sq_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int LOG2_L     = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear,
  output logic              busy,
  intpol2_sq_gen_if.master  bus
);

`ifdef INTPOL2_SQ_SAT_EN
  // Headroom so c*L^2 and the 2*y term never wrap before the clamp.
  localparam int c_IW = DATA_WIDTH + 2*LOG2_L + 2;
`else
  localparam int c_IW = DATA_WIDTH;
`endif
  localparam int              c_KW = LOG2_L + 1;
  localparam logic [c_KW-1:0] c_L  = c_KW'(1 << LOG2_L);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                  state_q;
  logic                    m_valid_q;
  logic                    m_last_q;
  logic [DATA_WIDTH-1:0]   m_data_q;
  logic [DATA_WIDTH-1:0]   m_data_d;
  logic signed [c_IW-1:0]  coef_q;
  logic signed [c_IW-1:0]  y_q;
  logic signed [c_IW-1:0]  yp_q;
  logic signed [c_IW-1:0]  y_d;
  logic signed [c_IW-1:0]  c_in;
  logic signed [c_IW-1:0]  y_sel;
  logic [c_KW-1:0]         k_q;
  logic [c_KW-1:0]         k_d;
  logic                    s_ready_w;
  logic                    accept;
  logic                    m_hs;

  assign m_hs      = m_valid_q & bus.m_ready;
  assign s_ready_w = ((state_q == IDLE) | (m_hs & m_last_q)) & ~clear;
  assign accept    = bus.s_valid & s_ready_w;

  assign c_in  = c_IW'($signed(bus.s_c));
  assign k_d   = k_q + c_KW'(1);
  assign y_d   = (k_d == c_KW'(2)) ? (coef_q <<< 2)
                                   : ((y_q <<< 1) - yp_q + (coef_q <<< 1));
  assign y_sel = accept ? c_in : y_d;

`ifdef INTPOL2_SQ_SAT_EN
  localparam logic signed [c_IW-1:0] c_MAX =
    {{(c_IW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [c_IW-1:0] c_MIN =
    {{(c_IW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  always_comb begin
    m_data_d = y_sel[DATA_WIDTH-1:0];
    if (y_sel > c_MAX) begin
      m_data_d = c_MAX[DATA_WIDTH-1:0];
    end else if (y_sel < c_MIN) begin
      m_data_d = c_MIN[DATA_WIDTH-1:0];
    end
  end
`else
  assign m_data_d = y_sel;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      coef_q    <= '0;
      y_q       <= '0;
      yp_q      <= '0;
      k_q       <= '0;
    end else if (clear) begin
      state_q   <= IDLE;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      coef_q    <= '0;
      y_q       <= '0;
      yp_q      <= '0;
      k_q       <= '0;
    end else if (accept) begin
      // Also covers the accept on the final beat: next burst starts with no bubble.
      state_q   <= RUN;
      m_valid_q <= 1'b1;
      m_last_q  <= 1'b0;
      m_data_q  <= m_data_d;
      coef_q    <= c_in;
      y_q       <= c_in;
      yp_q      <= '0;
      k_q       <= c_KW'(1);
    end else if (m_hs) begin
      if (m_last_q) begin
        state_q   <= IDLE;
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end else begin
        m_last_q <= (k_d == c_L);
        m_data_q <= m_data_d;
        k_q      <= k_d;
        y_q      <= y_d;
        yp_q     <= y_q;
      end
    end
  end

  assign bus.s_ready = s_ready_w;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_last  = m_last_q;
  assign busy        = (state_q == RUN);

endmodule
`default_nettype wire

// File: tb/tb_intpol2_sq_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_intpol2_sq_gen                                               |
// | Brief  : directed self-checking bench for intpol2_sq_gen                 |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_intpol2_sq_gen;

  logic clk;
  logic rstn;
  logic clear;
  logic busy_a, busy_b, busy_c;
  int   total;
  int   bad;

  intpol2_sq_gen_if #(.DATA_WIDTH(32)) ba ();
  intpol2_sq_gen_if #(.DATA_WIDTH(8))  bb ();
  intpol2_sq_gen_if #(.DATA_WIDTH(32)) bc ();

  intpol2_sq_gen #(.DATA_WIDTH(32), .LOG2_L(2)) u_a (
    .clk(clk), .rstn(rstn), .clear(clear), .busy(busy_a), .bus(ba)
  );
  intpol2_sq_gen #(.DATA_WIDTH(8), .LOG2_L(2)) u_b (
    .clk(clk), .rstn(rstn), .clear(clear), .busy(busy_b), .bus(bb)
  );
  intpol2_sq_gen #(.DATA_WIDTH(32), .LOG2_L(1)) u_c (
    .clk(clk), .rstn(rstn), .clear(clear), .busy(busy_c), .bus(bc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat_a(input string tag, input logic signed [63:0] d,
                        input logic l);
    chk({tag, ".valid"}, ba.m_valid, 1);
    chk({tag, ".data"}, $signed(ba.m_data), d);
    chk({tag, ".last"}, ba.m_last, l);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rstn  = 1'b0;
    clear = 1'b0;
    ba.s_valid = 0; ba.s_c = '0; ba.m_ready = 1;
    bb.s_valid = 0; bb.s_c = '0; bb.m_ready = 1;
    bc.s_valid = 0; bc.s_c = '0; bc.m_ready = 1;
    #12;
    chk("rst.valid", ba.m_valid, 0);
    chk("rst.last", ba.m_last, 0);
    chk("rst.data", $signed(ba.m_data), 0);
    chk("rst.busy", busy_a, 0);
    chk("rst.s_ready", ba.s_ready, 1);
    rstn = 1'b1;

    // c=3, free-running downstream
    ba.s_valid = 1; ba.s_c = 32'sd3;
    step(); ba.s_valid = 0;
    beat_a("c3.k1", 3, 0);
    chk("c3.busy", busy_a, 1);
    step(); beat_a("c3.k2", 12, 0);
    step(); beat_a("c3.k3", 27, 0);
    step(); beat_a("c3.k4", 48, 1);
    chk("c3.s_ready_last", ba.s_ready, 1);
    step();
    chk("c3.end.valid", ba.m_valid, 0);
    chk("c3.end.busy", busy_a, 0);

    // c=-5 with stalls
    ba.s_valid = 1; ba.s_c = -32'sd5;
    step(); ba.s_valid = 0;
    beat_a("m5.k1", -5, 0);
    step(); beat_a("m5.k2", -20, 0);
    ba.m_ready = 0;
    step(); beat_a("m5.stall1", -20, 0);
    step(); beat_a("m5.stall2", -20, 0);
    ba.m_ready = 1;
    step(); beat_a("m5.k3", -45, 0);
    ba.m_ready = 0;
    step(); beat_a("m5.stall3", -45, 0);
    ba.m_ready = 1;
    step(); beat_a("m5.k4", -80, 1);
    ba.m_ready = 0;
    step(); beat_a("m5.stall4", -80, 1);
    #1 chk("m5.s_ready_stalled", ba.s_ready, 0);
    ba.m_ready = 1;
    #1 chk("m5.s_ready_go", ba.s_ready, 1);
    step();
    chk("m5.end.valid", ba.m_valid, 0);

    // back-to-back bursts c=2 then c=7
    ba.s_valid = 1; ba.s_c = 32'sd2;
    step(); ba.s_c = 32'sd7;
    beat_a("b2.k1", 2, 0);
    chk("b2.s_ready_mid", ba.s_ready, 0);
    step(); beat_a("b2.k2", 8, 0);
    step(); beat_a("b2.k3", 18, 0);
    step(); beat_a("b2.k4", 32, 1);
    chk("b2.s_ready_last", ba.s_ready, 1);
    step(); ba.s_valid = 0;
    beat_a("b7.k1", 7, 0);
    step(); beat_a("b7.k2", 28, 0);
    step(); beat_a("b7.k3", 63, 0);
    step(); beat_a("b7.k4", 112, 1);
    step();
    chk("b7.end.valid", ba.m_valid, 0);

    // clear mid-burst, then a clean burst
    ba.s_valid = 1; ba.s_c = 32'sd9;
    step(); ba.s_valid = 0;
    beat_a("c9.k1", 9, 0);
    step(); beat_a("c9.k2", 36, 0);
    clear = 1'b1;
    ba.s_valid = 1; ba.s_c = 32'sd100;
    #1 chk("clr.s_ready", ba.s_ready, 0);
    step();
    clear = 1'b0;
    chk("clr.valid", ba.m_valid, 0);
    chk("clr.last", ba.m_last, 0);
    chk("clr.busy", busy_a, 0);
    chk("clr.data", $signed(ba.m_data), 0);
    ba.s_c = 32'sd1;
    step(); ba.s_valid = 0;
    beat_a("c1.k1", 1, 0);
    step(); beat_a("c1.k2", 4, 0);
    step(); beat_a("c1.k3", 9, 0);
    step(); beat_a("c1.k4", 16, 1);
    step();

    // 8-bit datapath, c=10: fourth sample overflows
    bb.s_valid = 1; bb.s_c = 8'sd10;
    step(); bb.s_valid = 0;
    chk("w8.k1", $signed(bb.m_data), 10);
    step(); chk("w8.k2", $signed(bb.m_data), 40);
    step(); chk("w8.k3", $signed(bb.m_data), 90);
    step();
`ifdef INTPOL2_SQ_SAT_EN
    chk("w8.k4", $signed(bb.m_data), 127);
`else
    chk("w8.k4", $signed(bb.m_data), -96);
`endif
    chk("w8.k4.last", bb.m_last, 1);
    step();
    chk("w8.end.valid", bb.m_valid, 0);

    // L=2 burst, c=6
    bc.s_valid = 1; bc.s_c = 32'sd6;
    step(); bc.s_valid = 0;
    chk("l2.k1", $signed(bc.m_data), 6);
    chk("l2.k1.last", bc.m_last, 0);
    step();
    chk("l2.k2", $signed(bc.m_data), 24);
    chk("l2.k2.last", bc.m_last, 1);
    step();
    chk("l2.end.valid", bc.m_valid, 0);

    // asynchronous reset mid-burst
    ba.s_valid = 1; ba.s_c = 32'sd3;
    step(); ba.s_valid = 0;
    step(); beat_a("ar.k2", 12, 0);
    #2 rstn = 1'b0;
    #1;
    chk("ar.valid", ba.m_valid, 0);
    chk("ar.data", $signed(ba.m_data), 0);
    chk("ar.last", ba.m_last, 0);
    chk("ar.busy", busy_a, 0);
    #10 rstn = 1'b1;
    step();
    chk("ar.idle", ba.m_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
